// File: rtl/motorb_relu_seq_ctrl_if.sv
// rtl/motorb_relu_seq_ctrl_if.sv - ap_ctrl_hs handshake and vector bus for the ReLU sequencer
//
// Purpose: bundles the ap_ctrl_hs control handshake together with the input and
//          result vectors of motorb_relu_seq_ctrl.
// Ports (signals):
//   ap_start      master->slave  request to process p_read_vec
//   p_read_vec    master->slave  N*W input lanes, lane k at [k*W +: W]
//   ap_idle       slave->master  block is idle
//   ap_ready      slave->master  one-cycle pulse, next ap_start can be taken
//   ap_done       slave->master  one-cycle pulse, ap_return_vec/clip_cnt valid
//   ap_return_vec slave->master  N*W ReLU results
//   clip_cnt      slave->master  lanes forced to zero in the last vector
interface motorb_relu_seq_ctrl_if #(
  parameter int N     = 9,
  parameter int W     = 32,
  parameter int CNT_W = 4
);
  logic             ap_start;
  logic             ap_idle;
  logic             ap_ready;
  logic             ap_done;
  logic [N*W-1:0]   p_read_vec;
  logic [N*W-1:0]   ap_return_vec;
  logic [CNT_W-1:0] clip_cnt;

  modport master (
    output ap_start, p_read_vec,
    input  ap_idle, ap_ready, ap_done, ap_return_vec, clip_cnt
  );

  modport slave (
    input  ap_start, p_read_vec,
    output ap_idle, ap_ready, ap_done, ap_return_vec, clip_cnt
  );
endinterface

// File: rtl/motorb_relu_seq_ctrl.sv
// rtl/motorb_relu_seq_ctrl.sv - time-multiplexed ReLU sequencer with ap_ctrl_hs handshake
//
// Purpose: latches an N-lane vector on ap_start, pushes one lane per clock through a
//          single shared compare/clamp stage and reports the results plus the number
//          of clamped lanes, pulsing ap_done/ap_ready for one cycle at completion.
// Ports:
//   ap_clk  clock, rising edge
//   ap_rst  asynchronous active-high reset
//   bus     slave modport: ap_start, p_read_vec in; ap_idle, ap_ready, ap_done,
//           ap_return_vec, clip_cnt out
module motorb_relu_seq_ctrl #(
  parameter int N     = 9,
  parameter int W     = 32,
  parameter int CNT_W = 4
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  motorb_relu_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] idx;
  logic [CNT_W-1:0] acc;
  logic [CNT_W-1:0] clip_cnt_q;
  logic [N*W-1:0]   shadow;
  logic [N*W-1:0]   ret_vec;
  logic             done_q;
  logic             ready_q;
  logic             idle_q;

  logic [W-1:0]     cur_x;
  logic [W-1:0]     cur_y;
  logic             cur_clip;
  logic [CNT_W-1:0] acc_next;

  // Shared lane: select the current lane from the shadow copy.
  always_comb begin
    cur_x = '0;
    for (int k = 0; k < N; k++) begin
      if (idx == CNT_W'(k)) cur_x = shadow[k*W +: W];
    end
  end

  // Non-positive means sign bit set or exactly zero; zero is clamped too.
  assign cur_clip = cur_x[W-1] || (cur_x == '0);
  assign cur_y    = cur_clip ? '0 : cur_x;
  assign acc_next = acc + {{(CNT_W-1){1'b0}}, cur_clip};

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      acc        <= '0;
      shadow     <= '0;
      ret_vec    <= '0;
      clip_cnt_q <= '0;
      done_q     <= 1'b0;
      ready_q    <= 1'b0;
      idle_q     <= 1'b1;
    end else begin
      case (state)
        // DONE behaves like IDLE for accepting a new vector, which gives
        // back-to-back operation without an idle bubble.
        S_IDLE, S_DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b0;
          if (bus.ap_start) begin
            shadow <= bus.p_read_vec;
            idx    <= '0;
            acc    <= '0;
            state  <= S_RUN;
            idle_q <= 1'b0;
          end else begin
            state  <= S_IDLE;
            idle_q <= 1'b1;
          end
        end

        S_RUN: begin
          for (int k = 0; k < N; k++) begin
            if (idx == CNT_W'(k)) ret_vec[k*W +: W] <= cur_y;
          end
          if (idx == CNT_W'(N-1)) begin
            clip_cnt_q <= acc_next;
            idx        <= '0;
            state      <= S_DONE;
            done_q     <= 1'b1;
            ready_q    <= 1'b1;
          end else begin
            idx <= idx + CNT_W'(1);
            acc <= acc_next;
          end
        end

        default: begin
          state   <= S_IDLE;
          idle_q  <= 1'b1;
          done_q  <= 1'b0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ap_idle       = idle_q;
  assign bus.ap_done       = done_q;
  assign bus.ap_ready      = ready_q;
  assign bus.ap_return_vec = ret_vec;
  assign bus.clip_cnt      = clip_cnt_q;

endmodule

// File: tb/tb_motorb_relu_seq_ctrl.sv
// tb/tb_motorb_relu_seq_ctrl.sv - scoreboard bench for motorb_relu_seq_ctrl
module tb_motorb_relu_seq_ctrl;
  localparam int N     = 9;
  localparam int W     = 32;
  localparam int CNT_W = 4;

  typedef logic [N*W-1:0] vec_t;
  typedef struct {
    vec_t res;
    int   clip;
    int   acc_cyc;
  } exp_t;

  logic ap_clk = 1'b0;
  logic ap_rst = 1'b0;

  motorb_relu_seq_ctrl_if #(.N(N), .W(W), .CNT_W(CNT_W)) bus ();

  motorb_relu_seq_ctrl #(.N(N), .W(W), .CNT_W(CNT_W)) dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .bus    (bus.slave)
  );

  always #5 ap_clk = ~ap_clk;

  exp_t sb[$];
  int   checks    = 0;
  int   errors    = 0;
  int   cyc       = 0;
  int   lock      = 0;
  int   n_acc     = 0;

  task automatic chk(input string name, input vec_t act, input vec_t req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Golden ReLU over the whole vector plus the count of clamped lanes.
  function automatic exp_t relu_model(input vec_t v, input int at);
    exp_t e;
    int   x;
    e.res     = '0;
    e.clip    = 0;
    e.acc_cyc = at;
    for (int k = 0; k < N; k++) begin
      x = int'(v[k*W +: W]);
      if (x > 0) e.res[k*W +: W] = v[k*W +: W];
      else       e.clip++;
    end
    return e;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int k = 0; k < N; k++) begin
      v[k*W +: W] = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom());
    end
    return v;
  endfunction

  // Reference timing: a vector accepted at edge t makes the block deaf to
  // ap_start for the next N edges; its result is due in the cycle after edge t+N.
  initial forever begin
    @(posedge ap_clk);
    if (!ap_rst) begin
      cyc++;
      if (lock > 0) begin
        lock--;
      end else if (bus.ap_start) begin
        sb.push_back(relu_model(bus.p_read_vec, cyc));
        lock = N;
        n_acc++;
      end
    end
  end

  // Monitor: compares handshake every cycle and pops a result on each ap_done.
  initial forever begin
    exp_t e;
    logic exp_done;
    @(negedge ap_clk);
    if (!ap_rst) begin
      exp_done = (sb.size() > 0) && (sb[0].acc_cyc + N == cyc);
      chk("ap_done", vec_t'(bus.ap_done), vec_t'(exp_done));
      chk("ap_ready", vec_t'(bus.ap_ready), vec_t'(exp_done));
      chk("ap_idle", vec_t'(bus.ap_idle), vec_t'((lock == 0) && !exp_done));
      if (exp_done) begin
        e = sb.pop_front();
        chk("sb_result", bus.ap_return_vec, e.res);
        chk("sb_clip_cnt", vec_t'(bus.clip_cnt), vec_t'(e.clip));
      end
    end
  end

  task automatic issue(input vec_t v, output int t);
    @(negedge ap_clk);
    bus.ap_start   = 1'b1;
    bus.p_read_vec = v;
    @(negedge ap_clk);
    t              = cyc;
    bus.ap_start   = 1'b0;
    bus.p_read_vec = rand_vec();
  endtask

  // Waits a bounded time for ap_done while scrambling the input bus.
  task automatic wait_done(input int t, input string tag);
    for (int i = 0; i < N + 5; i++) begin
      if (bus.ap_done) break;
      @(negedge ap_clk);
      bus.p_read_vec = rand_vec();
    end
    chk({tag, "_done_seen"}, vec_t'(bus.ap_done), vec_t'(1));
    chk({tag, "_latency"}, vec_t'(cyc - t), vec_t'(N));
  endtask

  initial begin
    logic [W-1:0] lanes   [N];
    logic [W-1:0] exp_l   [N];
    vec_t         mix_v, mix_e, pos_v;
    int           t;
    int           guard;

    bus.ap_start   = 1'b0;
    bus.p_read_vec = '0;

    // Reset asserted mid-cycle before any clock edge: outputs take effect at once.
    #3 ap_rst = 1'b1;
    #1;
    chk("rst_idle", vec_t'(bus.ap_idle), vec_t'(1));
    chk("rst_done", vec_t'(bus.ap_done), vec_t'(0));
    chk("rst_ready", vec_t'(bus.ap_ready), vec_t'(0));
    chk("rst_ret", bus.ap_return_vec, '0);
    chk("rst_clip", vec_t'(bus.clip_cnt), vec_t'(0));
    repeat (2) @(negedge ap_clk);
    ap_rst = 1'b0;

    // Mixed-sign directed vector.
    lanes = '{32'h01000000, 32'hFF000000, 32'h0, 32'h00000001, 32'h80000000,
              32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00800000, 32'h00000000};
    exp_l = '{32'h01000000, 32'h0, 32'h0, 32'h00000001, 32'h0,
              32'h7FFFFFFF, 32'h0, 32'h00800000, 32'h0};
    for (int k = 0; k < N; k++) begin
      mix_v[k*W +: W] = lanes[k];
      mix_e[k*W +: W] = exp_l[k];
    end
    issue(mix_v, t);
    wait_done(t, "mixed");
    chk("mixed_result", bus.ap_return_vec, mix_e);
    chk("mixed_clip", vec_t'(bus.clip_cnt), vec_t'(5));

    // Back-to-back: ap_start held high across several vectors.
    repeat (N + 3) @(negedge ap_clk);
    bus.ap_start = 1'b1;
    repeat (5 * (N + 1)) begin
      bus.p_read_vec = rand_vec();
      @(negedge ap_clk);
    end
    bus.ap_start = 1'b0;

    // Abort at lane index 4, then restart with an all-positive vector.
    repeat (N + 3) @(negedge ap_clk);
    issue(rand_vec(), t);
    while (cyc < t + 4) @(negedge ap_clk);
    #2 ap_rst = 1'b1;
    sb.delete();
    lock = 0;
    #1;
    chk("abort_ret", bus.ap_return_vec, '0);
    chk("abort_idle", vec_t'(bus.ap_idle), vec_t'(1));
    chk("abort_done", vec_t'(bus.ap_done), vec_t'(0));
    @(negedge ap_clk);
    ap_rst = 1'b0;
    for (int k = 0; k < N; k++) pos_v[k*W +: W] = 32'($urandom_range(1, 32'h7FFFFFFF));
    issue(pos_v, t);
    wait_done(t, "restart");
    chk("restart_result", bus.ap_return_vec, pos_v);
    chk("restart_clip", vec_t'(bus.clip_cnt), vec_t'(0));

    // Random traffic with random ap_start gaps.
    repeat (N + 3) @(negedge ap_clk);
    n_acc = 0;
    guard = 0;
    while (n_acc < 1000 && guard < 40000) begin
      bus.ap_start   = ($urandom_range(0, 3) != 0);
      bus.p_read_vec = rand_vec();
      @(negedge ap_clk);
      guard++;
    end
    bus.ap_start = 1'b0;
    chk("random_accepted", vec_t'(n_acc >= 1000), vec_t'(1));

    guard = 0;
    while (sb.size() != 0 && guard < 3 * N) begin
      @(negedge ap_clk);
      guard++;
    end
    repeat (2) @(negedge ap_clk);
    chk("drain_empty", vec_t'(sb.size()), vec_t'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
